// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one ddr_ctrl_wrapper port among NUM_PORTS requesters.
// Define DDR_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead.
module ddr_port_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                   local_clk_i,
  input  logic                   local_reset_n_i,
  input  logic [NUM_PORTS-1:0]   m_acc_i,
  input  logic [NUM_PORTS-1:0]   m_we_i,
  input  logic [NUM_PORTS*32-1:0] m_adr_i,
  input  logic [NUM_PORTS*32-1:0] m_dat_i,
  input  logic [NUM_PORTS*4-1:0] m_sel_i,
  input  logic [NUM_PORTS*4-1:0] m_buf_width_i,
  output logic [NUM_PORTS-1:0]   m_ack_o,
  output logic [31:0]            m_dat_o,
  output logic [NUM_PORTS-1:0]   grant_o,
  output logic                   ctrl_acc_o,
  output logic                   ctrl_we_o,
  output logic [31:0]            ctrl_adr_o,
  output logic [31:0]            ctrl_dat_o,
  output logic [3:0]             ctrl_sel_o,
  output logic [3:0]             ctrl_buf_width_o,
  input  logic                   ctrl_ack_i,
  input  logic [31:0]            ctrl_dat_i,
  input  logic                   ctrl_idle_i
);
  localparam int IW = (NUM_PORTS > 2) ? 2 : 1;

  // Handshake: a requester holds acc high; each ack completes one beat, and the
  // grant is held until the full burst (1 write beat or 1<<buf_width read beats) is acked.
  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic                 we_q, we_d;
  logic [3:0]           bw_q, bw_d;
  logic [16:0]          len_q, len_d;
  logic [16:0]          cnt_q, cnt_d;
  logic [IW-1:0]        win_idx;
  logic                 win_found;
  logic                 start_grant;
  logic                 busy;

  assign win_found   = |m_acc_i;
  assign start_grant = (state_q == ST_ARB) && ctrl_idle_i && win_found;

`ifdef DDR_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (m_acc_i[p]) win_idx = IW'(p);
    end
  end
`else
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the port right after the last winner wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_PORTS);
      if (m_acc_i[cand]) win_idx = cand;
    end
  end

  assign last_d = start_grant ? win_idx : last_q;

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) last_q <= IW'(NUM_PORTS - 1);
    else                  last_q <= last_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    we_d    = we_q;
    bw_d    = bw_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARB: begin
        if (start_grant) begin
          state_d = ST_BUSY;
          grant_d = NUM_PORTS'(1) << win_idx;
          gidx_d  = win_idx;
          we_d    = m_we_i[win_idx];
          bw_d    = m_buf_width_i[int'(win_idx)*4 +: 4];
          len_d   = m_we_i[win_idx] ? 17'd1
                                    : (17'd1 << m_buf_width_i[int'(win_idx)*4 +: 4]);
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (ctrl_ack_i) begin
          cnt_d = cnt_q + 17'd1;
          if (cnt_q == len_q - 17'd1) begin
            state_d = ST_RELEASE;
            grant_d = '0;
          end
        end
      end
      ST_RELEASE: state_d = ST_ARB;
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      gidx_q  <= '0;
      we_q    <= 1'b0;
      bw_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      bw_q    <= bw_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address/data/select follow the granted port live; acks are swallowed once it drops acc.
  assign busy             = (state_q == ST_BUSY);
  assign grant_o          = grant_q;
  assign ctrl_acc_o       = busy;
  assign ctrl_we_o        = busy & we_q;
  assign ctrl_buf_width_o = busy ? bw_q : 4'd0;
  assign ctrl_adr_o       = busy ? m_adr_i[int'(gidx_q)*32 +: 32] : 32'd0;
  assign ctrl_dat_o       = busy ? m_dat_i[int'(gidx_q)*32 +: 32] : 32'd0;
  assign ctrl_sel_o       = busy ? m_sel_i[int'(gidx_q)*4 +: 4] : 4'd0;
  assign m_ack_o          = (busy && ctrl_ack_i) ? (grant_q & m_acc_i) : '0;
  assign m_dat_o          = ctrl_dat_i;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: vector table, directed corner sequences and random
// traffic against a transaction-level model (honours DDR_ARB_FIXED_PRIO_EN).
module tb_ddr_port_arbiter;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   m_acc, m_we, m_ack, grant;
  logic [NP*32-1:0] m_adr, m_dat_w;
  logic [NP*4-1:0] m_sel, m_bw;
  logic [31:0]     m_dat_o, c_adr, c_dat, c_dat_in;
  logic            c_acc, c_we, c_ack, c_idle;
  logic [3:0]      c_sel, c_bw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.NUM_PORTS(NP)) dut (
    .local_clk_i(clk), .local_reset_n_i(rst_n),
    .m_acc_i(m_acc), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat_w),
    .m_sel_i(m_sel), .m_buf_width_i(m_bw),
    .m_ack_o(m_ack), .m_dat_o(m_dat_o), .grant_o(grant),
    .ctrl_acc_o(c_acc), .ctrl_we_o(c_we), .ctrl_adr_o(c_adr), .ctrl_dat_o(c_dat),
    .ctrl_sel_o(c_sel), .ctrl_buf_width_o(c_bw),
    .ctrl_ack_i(c_ack), .ctrl_dat_i(c_dat_in), .ctrl_idle_i(c_idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the port, beats still owed, cooldown cycles.
  int owner, beats_left, cool, last_w;
  logic lw;
  logic [3:0] lbw;

  function automatic int pick(input logic [NP-1:0] req);
`ifdef DDR_ARB_FIXED_PRIO_EN
    for (int p = 0; p < NP; p++) if (req[p]) return p;
`else
    for (int k = 1; k <= NP; k++) if (req[(last_w + k) % NP]) return (last_w + k) % NP;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; beats_left = 0; cool = 0; last_w = NP - 1; lw = 1'b0; lbw = 4'd0;
  endtask

  // Called at posedge+4 with inputs stable: compare everything, step model, move to next posedge+1.
  task automatic check_and_advance();
    logic [NP-1:0] one, eg, ea;
    logic b;
    one = 1;
    b   = (owner >= 0);
    eg  = b ? (one << owner) : '0;
    ea  = (b && c_ack && m_acc[owner]) ? eg : '0;
    chk("grant", grant, eg);
    chk("ctrl_acc", c_acc, b);
    chk("m_ack", m_ack, ea);
    chk("ctrl_we", c_we, b ? lw : 1'b0);
    chk("ctrl_bw", c_bw, b ? lbw : 4'd0);
    chk("ctrl_adr", c_adr, b ? m_adr[owner*32 +: 32] : 32'd0);
    chk("ctrl_dat", c_dat, b ? m_dat_w[owner*32 +: 32] : 32'd0);
    chk("ctrl_sel", c_sel, b ? m_sel[owner*4 +: 4] : 4'd0);
    chk("m_dat", m_dat_o, c_dat_in);
    if (b) begin
      if (c_ack) begin
        beats_left--;
        if (beats_left == 0) begin owner = -1; cool = 1; end
      end
    end else if (cool > 0) begin
      cool--;
    end else if (c_idle && m_acc != '0) begin
      owner = pick(m_acc);
      last_w = owner;
      lw = m_we[owner];
      lbw = m_bw[owner*4 +: 4];
      beats_left = lw ? 1 : (1 << lbw);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [NP-1:0] acc, we;
    logic idle, ack;
    logic [NP-1:0] e_grant;
    logic e_cacc;
    logic [NP-1:0] e_mack;
    logic [31:0] e_adr;
  } vec_t;
  vec_t vt[11];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, pulses, nseen;
    logic [NP-1:0] seen[4];
    logic [NP-1:0] exp_g;

    model_reset();
    m_acc = '0; m_we = '0; m_bw = '0; c_ack = 1'b0; c_idle = 1'b1; c_dat_in = '0;
    m_adr = {32'h0000_0200, 32'h0000_0100};
    m_dat_w = {32'h1234_5678, 32'hDEAD_BEEF};
    m_sel = {4'h3, 4'hF};
    #12;
    chk("rst_grant", grant, 0); chk("rst_ctrl_acc", c_acc, 0); chk("rst_m_ack", m_ack, 0);
    chk("rst_ctrl_adr", c_adr, 0); chk("rst_ctrl_we", c_we, 0); chk("rst_ctrl_bw", c_bw, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write on port 0, then wrapper-busy hold-off and a 1-beat read on port 1.
    vt[0]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[1]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 32'h100};
    vt[2]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[3]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[5]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[6]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[7]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 32'h200};
    vt[8]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 32'h200};
    vt[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vt[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    for (int i = 0; i < 11; i++) begin
      m_acc = vt[i].acc; m_we = vt[i].we; c_idle = vt[i].idle; c_ack = vt[i].ack;
      c_dat_in = $urandom;
      #3;
      chk($sformatf("vec%0d_grant", i), grant, vt[i].e_grant);
      chk($sformatf("vec%0d_ctrl_acc", i), c_acc, vt[i].e_cacc);
      chk($sformatf("vec%0d_m_ack", i), m_ack, vt[i].e_mack);
      chk($sformatf("vec%0d_ctrl_adr", i), c_adr, vt[i].e_adr);
      check_and_advance();
    end

    // Read burst of 8 on port 1 with ack gaps.
    m_bw = {4'd3, 4'd0}; m_acc = 2'b10; m_we = 2'b00; c_idle = 1'b1;
    acks = 0; pulses = 0;
    for (int i = 0; i < 40 && acks < 8; i++) begin
      c_ack = (grant != '0) && (i % 3 != 2);
      c_dat_in = $urandom;
      #3;
      if (c_ack) begin
        acks++;
        if (m_ack[1]) pulses++;
      end
      check_and_advance();
    end
    chk("burst_ack_pulses", pulses, 8);
    m_acc = '0; c_ack = 1'b0;
    #3; chk("burst_grant_drop", grant, 0); check_and_advance();
    #3; check_and_advance();

    // Contention: both ports issue writes continuously.
    m_acc = 2'b11; m_we = 2'b11; m_bw = '0;
    nseen = 0;
    for (int k = 0; k < 4; k++) seen[k] = '0;
    for (int i = 0; i < 40 && nseen < 4; i++) begin
      c_ack = (grant != '0);
      if (grant != '0) begin seen[nseen] = grant; nseen++; end
      #3; check_and_advance();
    end
    for (int k = 0; k < 4; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("contend_grant%0d", k), seen[k], exp_g);
    end
    m_acc = '0; c_ack = 1'b0;
    #3; check_and_advance();
    #3; check_and_advance();

    // Port 0 abandons a 4-beat read after 2 acks.
    m_acc = 2'b01; m_we = 2'b00; m_bw = {4'd0, 4'd2};
    acks = 0;
    for (int i = 0; i < 30 && acks < 4; i++) begin
      if (acks >= 2) m_acc = 2'b00;
      c_ack = (grant != '0);
      #3;
      if (c_ack) begin
        acks++;
        chk($sformatf("abort_ctrl_acc_beat%0d", acks), c_acc, 1);
        chk($sformatf("abort_m_ack_beat%0d", acks), m_ack[0], acks <= 2);
      end
      check_and_advance();
    end
    m_acc = '0; c_ack = 1'b0;
    #3; chk("abort_release_acc", c_acc, 0); chk("abort_release_grant", grant, 0);
    check_and_advance();
    #3; check_and_advance();

    // Asynchronous reset during the third beat of a port 1 burst.
    m_acc = 2'b10; m_we = 2'b00; m_bw = {4'd3, 4'd0};
    acks = 0;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      c_ack = (grant != '0);
      #3;
      if (c_ack) acks++;
      check_and_advance();
    end
    c_ack = 1'b1; c_dat_in = '0;
    #1; chk("rstmid_pre_busy", c_acc, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_grant", grant, 0); chk("rstmid_ctrl_acc", c_acc, 0); chk("rstmid_m_ack", m_ack, 0);
    chk("rstmid_ctrl_adr", c_adr, 0); chk("rstmid_ctrl_dat", c_dat, 0); chk("rstmid_ctrl_sel", c_sel, 0);
    chk("rstmid_ctrl_we", c_we, 0); chk("rstmid_ctrl_bw", c_bw, 0); chk("rstmid_m_dat", m_dat_o, 0);
    model_reset();
    c_ack = 1'b0; m_acc = 2'b11; m_we = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3; check_and_advance();
    c_ack = 1'b1;
    #3; chk("rstmid_first_grant", grant, 2'b01); check_and_advance();
    m_acc = '0; c_ack = 1'b0;
    #3; check_and_advance();
    #3; check_and_advance();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++) begin
        m_acc[p] = ($urandom_range(0, 3) != 0);
        m_we[p] = 1'($urandom_range(0, 1));
        m_bw[p*4 +: 4] = 4'($urandom_range(0, 3));
        m_adr[p*32 +: 32] = $urandom;
        m_dat_w[p*32 +: 32] = $urandom;
        m_sel[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      c_idle = ($urandom_range(0, 3) != 0);
      c_ack = 1'($urandom_range(0, 1));
      c_dat_in = $urandom;
      #3; check_and_advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
